// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous byte FIFO and sends each one as a
// UART frame: 1 start bit, 8 data bits LSB first, optional even parity, 1 stop bit.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_next;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_cnt_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             parity;
    logic             parity_next;
    logic             baud_done;
    logic             tx_next;
    logic             rd_en_next;
    logic             busy_next;
    logic             frame_done_next;

    assign baud_done = (baud_cnt == BAUD_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; fifo_empty only matters when deciding in IDLE
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: state_next = S_WAIT;
            S_WAIT:  state_next = S_START;
            S_START: begin
                if (baud_done) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done && (bit_cnt == BIT_LAST)) begin
                    state_next = PARITY_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (baud_done) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Baud/bit counters and shift register; byte is captured in WAIT when FIFO data is valid
    always_comb begin
        baud_cnt_next = baud_cnt;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;
        parity_next   = parity;
        case (state)
            S_WAIT: begin
                shift_next    = fifo_data;
                parity_next   = ^fifo_data;
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
            end
            S_START, S_PARITY, S_STOP: begin
                baud_cnt_next = baud_done ? '0 : baud_cnt + CNT_W'(1);
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_cnt_next = '0;
                    shift_next    = {1'b0, shift[7:1]};
                    bit_cnt_next  = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
                end else begin
                    baud_cnt_next = baud_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
        end else begin
            baud_cnt <= baud_cnt_next;
            bit_cnt  <= bit_cnt_next;
            shift    <= shift_next;
            parity   <= parity_next;
        end
    end

    // Output decode from the upcoming state so registered outputs line up with it
    always_comb begin
        tx_next         = 1'b1;
        rd_en_next      = 1'b0;
        busy_next       = (state_next != S_IDLE);
        frame_done_next = (state == S_STOP) && (state_next == S_IDLE);
        case (state_next)
            S_FETCH:  rd_en_next = 1'b1;
            S_START:  tx_next    = 1'b0;
            S_DATA:   tx_next    = shift_next[0];
            S_PARITY: tx_next    = parity;
            default:  ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx         <= tx_next;
            fifo_rd_en <= rd_en_next;
            busy       <= busy_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two instances (no parity / even parity) fed by a FIFO model;
// a negedge monitor decodes frames and checks them against a scoreboard queue.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int NB0 = 10;
    localparam int NB1 = 11;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       empty0, empty1;
    logic [7:0] data0, data1;
    logic       rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .fifo_empty(empty0), .fifo_data(data0),
        .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .frame_done(done0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .fifo_empty(empty1), .fifo_data(data1),
        .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .frame_done(done1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // FIFO model state (stimulus side)
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         st0 = 0, st1 = 0;
    logic [7:0] held0 = 8'h00, held1 = 8'h00;

    // Scoreboard and monitor state
    exp_t        exp0[$];
    exp_t        exp1[$];
    int          k[2]        = '{0, 0};
    bit          in_frame[2] = '{1'b0, 1'b0};
    logic [10:0] bits[2];
    bit          stable[2]   = '{1'b1, 1'b1};
    logic        prev_tx[2]  = '{1'b1, 1'b1};
    logic        prev_rd[2]  = '{1'b0, 1'b0};
    int          rd_cyc[2]   = '{0, 0};
    int          fd_due[2]   = '{-1, -1};
    int          nfd[2]      = '{0, 0};
    int          npop[2]     = '{0, 0};
    int          nabort[2]   = '{0, 0};
    int          nstart[2]   = '{0, 0};
    int          starts[2][8];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Frame decoder and checker for one lane, run once per cycle at negedge
    task automatic mon_step(input int ln, input logic t, input logic rd, input logic bz, input logic fd);
        int          nb;
        int          sz;
        exp_t        e;
        logic [10:0] want;
        nb = (ln == 0) ? NB0 : NB1;
        if (reset) begin
            if (in_frame[ln]) begin
                nabort[ln]++;
                if (ln == 0) begin
                    if (exp0.size() > 0) e = exp0.pop_front();
                end else begin
                    if (exp1.size() > 0) e = exp1.pop_front();
                end
            end
            in_frame[ln] = 1'b0;
            fd_due[ln]   = -1;
            prev_tx[ln]  = 1'b1;
            prev_rd[ln]  = 1'b0;
            return;
        end
        if (rd) begin
            npop[ln]++;
            check($sformatf("rd_en_width%0d", ln), 32'(prev_rd[ln]), 32'd0);
            rd_cyc[ln] = cyc;
        end
        if (fd) begin
            nfd[ln]++;
            check($sformatf("frame_done_time%0d", ln), 32'(cyc), 32'(fd_due[ln]));
            fd_due[ln] = -1;
        end else if (fd_due[ln] == cyc) begin
            check($sformatf("frame_done_missing%0d", ln), 32'(fd), 32'd1);
            fd_due[ln] = -1;
        end
        if (!in_frame[ln] && prev_tx[ln] && !t) begin
            in_frame[ln] = 1'b1;
            k[ln]        = 0;
            bits[ln]     = '0;
            stable[ln]   = 1'b1;
            check($sformatf("start_latency%0d", ln), 32'(cyc - rd_cyc[ln]), 32'd2);
            if (nstart[ln] < 8) starts[ln][nstart[ln]] = cyc;
            nstart[ln]++;
        end
        if (in_frame[ln]) begin
            if (k[ln] % CPB == 0) bits[ln][k[ln] / CPB] = t;
            else if (t !== bits[ln][k[ln] / CPB]) stable[ln] = 1'b0;
            if (!bz) stable[ln] = 1'b0;
            if (k[ln] == nb * CPB - 1) begin
                sz = (ln == 0) ? exp0.size() : exp1.size();
                check($sformatf("exp_queue%0d", ln), 32'(sz > 0), 32'd1);
                e = '0;
                if (sz > 0) e = (ln == 0) ? exp0.pop_front() : exp1.pop_front();
                if (ln == 0) want = {1'b0, 1'b1, e.data, 1'b0};
                else         want = {1'b1, e.par, e.data, 1'b0};
                check($sformatf("frame_bits%0d", ln), 32'(bits[ln]), 32'(want));
                check($sformatf("frame_stable_busy%0d", ln), 32'(stable[ln]), 32'd1);
                in_frame[ln] = 1'b0;
                fd_due[ln]   = cyc + 1;
            end else begin
                k[ln]++;
            end
        end
        prev_tx[ln] = t;
        prev_rd[ln] = rd;
    endtask

    // Monitor: samples both lanes away from the active edge
    always @(negedge clk) begin
        mon_step(0, tx0, rd0, busy0, done0);
        mon_step(1, tx1, rd1, busy1, done1);
    end

    // FIFO read model: data appears the cycle after the pop and is junk otherwise
    task automatic fifo_model();
        if (st0 == 1) begin data0 = held0; st0 = 2; end
        else if (st0 == 2) begin data0 = ~held0; st0 = 0; end
        if (rd0) begin
            check("fifo0_pop_nonempty", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) held0 = q0.pop_front();
            st0 = 1;
        end
        empty0 = (q0.size() == 0);
        if (st1 == 1) begin data1 = held1; st1 = 2; end
        else if (st1 == 2) begin data1 = ~held1; st1 = 0; end
        if (rd1) begin
            check("fifo1_pop_nonempty", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) held1 = q1.pop_front();
            st1 = 1;
        end
        empty1 = (q1.size() == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        fifo_model();
    endtask

    task automatic load(input int ln, input logic [7:0] d, input logic p);
        exp_t e;
        e.data = d;
        e.par  = p;
        if (ln == 0) begin q0.push_back(d); exp0.push_back(e); empty0 = 1'b0; end
        else         begin q1.push_back(d); exp1.push_back(e); empty1 = 1'b0; end
    endtask

    task automatic wait_fd(input int ln, input int target, input int budget);
        int n;
        n = 0;
        while (nfd[ln] < target && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("frame_done_count%0d", ln), 32'(nfd[ln]), 32'(target));
    endtask

    initial begin
        int sb;
        int s;
        int n;
        reset  = 1'b1;
        empty0 = 1'b1;
        empty1 = 1'b1;
        data0  = 8'h00;
        data1  = 8'h00;

        // Reset held with a byte waiting: outputs stay at reset values
        load(0, 8'hA5, 1'b0);
        repeat (3) begin
            tick();
            check("reset_outputs", 32'({tx0, rd0, busy0, done0}), 32'b1000);
        end
        reset = 1'b0;
        tick();
        check("first_rd_after_reset", 32'({rd0, busy0}), 32'b11);
        tick();
        check("rd_single_cycle", 32'(rd0), 32'd0);
        wait_fd(0, 1, 200);
        tick();
        check("idle_after_a5", 32'({tx0, rd0, busy0}), 32'b100);

        // Even parity lane: 0x07 (parity 1) then 0x03 (parity 0), back to back
        load(1, 8'h07, 1'b1);
        load(1, 8'h03, 1'b0);
        wait_fd(1, 2, 300);
        check("parity_gap", 32'(starts[1][1] - starts[1][0]), 32'd47);

        // Three-byte burst with fifo_empty low throughout
        sb = nstart[0];
        n  = npop[0];
        load(0, 8'h3C, 1'b0);
        load(0, 8'h81, 1'b0);
        load(0, 8'h00, 1'b0);
        wait_fd(0, 4, 600);
        check("burst_pops", 32'(npop[0] - n), 32'd3);
        check("burst_gap1", 32'(starts[0][sb + 1] - starts[0][sb]), 32'd43);
        check("burst_gap2", 32'(starts[0][sb + 2] - starts[0][sb + 1]), 32'd43);
        tick();
        tick();
        check("idle_after_burst", 32'({tx0, rd0, busy0}), 32'b100);

        // Reset during data bit 3 of 0x5A; 0xC3 must follow cleanly
        s = nstart[0];
        load(0, 8'h5A, 1'b0);
        load(0, 8'hC3, 1'b0);
        n = 0;
        while (nstart[0] == s && n < 20) begin
            tick();
            n++;
        end
        check("mid_frame_start_seen", 32'(nstart[0]), 32'(s + 1));
        repeat (17) tick();
        reset = 1'b1;
        tick();
        check("reset_mid_frame", 32'({tx0, rd0, busy0, done0}), 32'b1000);
        reset = 1'b0;
        wait_fd(0, 5, 300);
        check("aborted_frames", 32'(nabort[0]), 32'd1);

        // FIFO stays empty: line idle, no pops
        repeat (20) begin
            tick();
            check("idle_empty", 32'({tx0, rd0, busy0}), 32'b100);
        end

        check("total_pops0", 32'(npop[0]), 32'd6);
        check("total_pops1", 32'(npop[1]), 32'd2);
        check("scoreboard_drained0", 32'(exp0.size()), 32'd0);
        check("scoreboard_drained1", 32'(exp1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
